// File: rtl/mips_cpu_run_ctrl_pkg.sv
// Shared types and constants for the CPU run controller: FSM states, result codes
// and the default signature-write address and value.
package mips_cpu_run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } run_state_t;

  localparam logic [1:0] RES_HALT    = 2'd0;
  localparam logic [1:0] RES_PASS    = 2'd1;
  localparam logic [1:0] RES_FAIL    = 2'd2;
  localparam logic [1:0] RES_TIMEOUT = 2'd3;

  localparam logic [31:0] DEF_SIG_ADDR   = 32'h0000_0FFC;
  localparam logic [31:0] DEF_PASS_VALUE = 32'h0000_0001;

endpackage

// File: rtl/mips_pc_halt_det.sv
// PC stable detector: halt is asserted combinationally in the cycle where pc has matched
// the previous-cycle pc HALT_REPEAT times in a row. clear drops history (no valid previous pc).
module mips_pc_halt_det #(
  parameter int PC_WIDTH    = 32,
  parameter int HALT_REPEAT = 4
) (
  input  logic                clk,
  input  logic                clear,
  input  logic [PC_WIDTH-1:0] pc,
  output logic                halt
);

  localparam int CW = (HALT_REPEAT < 1) ? 1 : $clog2(HALT_REPEAT + 1);
  localparam logic [CW:0] LIMIT   = (CW + 1)'(HALT_REPEAT);
  localparam logic [CW:0] CNT_ONE = (CW + 1)'(1);

  logic [PC_WIDTH-1:0] prev_pc;
  logic                prev_vld;
  logic [CW-1:0]       stable_cnt;
  logic                same;
  logic [CW:0]         cnt_inc;

  assign same    = prev_vld && (pc == prev_pc);
  assign cnt_inc = {1'b0, stable_cnt} + CNT_ONE;
  // Once halt fires the controller leaves RUN, so the counter never passes LIMIT.
  assign halt    = (HALT_REPEAT != 0) && same && (cnt_inc >= LIMIT);

  always_ff @(posedge clk) begin
    if (clear) begin
      prev_vld   <= 1'b0;
      prev_pc    <= '0;
      stable_cnt <= '0;
    end else begin
      prev_vld <= 1'b1;
      prev_pc  <= pc;
      if (!same) begin
        stable_cnt <= '0;
      end else if (!halt) begin
        stable_cnt <= cnt_inc[CW-1:0];
      end
    end
  end

endmodule

// File: rtl/mips_cpu_run_ctrl.sv
// Run controller for a MIPS core under test: sequences core reset, runs until a signature
// write, a halted PC or a timeout, then freezes the core and reports the outcome.
module mips_cpu_run_ctrl
  import mips_cpu_run_ctrl_pkg::*;
#(
  parameter int          PC_WIDTH       = 32,
  parameter int          CNT_WIDTH      = 32,
  parameter int          RESET_CYCLES   = 2,
  parameter int          TIMEOUT_CYCLES = 250,
  parameter int          HALT_REPEAT    = 4,
  parameter logic [31:0] SIG_ADDR       = DEF_SIG_ADDR,
  parameter logic [31:0] PASS_VALUE     = DEF_PASS_VALUE
) (
  input  logic                 mips_cpu_clk,
  input  logic                 mips_cpu_reset,
  input  logic                 start,
  output logic                 core_reset,
  input  logic [PC_WIDTH-1:0]  pc,
  input  logic                 mem_wen,
  input  logic [31:0]          mem_addr,
  input  logic [31:0]          mem_wdata,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           result,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [PC_WIDTH-1:0]  halt_pc
);

  localparam int RW = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES);
  localparam logic [RW-1:0]        RST_LAST     = RW'(RESET_CYCLES - 1);
  localparam logic [RW-1:0]        RST_ONE      = RW'(1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);

  run_state_t    state, state_nxt;
  logic [RW-1:0] rst_cnt;
  logic          sig_hit, halt, timeout_hit, det_clear;
  logic [1:0]    res_nxt;

  assign det_clear = mips_cpu_reset || (state != ST_RUN);

  mips_pc_halt_det #(
    .PC_WIDTH   (PC_WIDTH),
    .HALT_REPEAT(HALT_REPEAT)
  ) u_halt_det (
    .clk  (mips_cpu_clk),
    .clear(det_clear),
    .pc   (pc),
    .halt (halt)
  );

  always_ff @(posedge mips_cpu_clk) begin
    if (mips_cpu_reset) state <= ST_IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    sig_hit     = mem_wen && (mem_addr == SIG_ADDR);
    timeout_hit = (cycle_count == TIMEOUT_LAST);
    res_nxt     = RES_TIMEOUT;
    // Signature beats halt beats timeout when they land on the same cycle.
    if (sig_hit)   res_nxt = (mem_wdata == PASS_VALUE) ? RES_PASS : RES_FAIL;
    else if (halt) res_nxt = RES_HALT;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_RESET;
      ST_RESET: if (rst_cnt == RST_LAST) state_nxt = ST_RUN;
      ST_RUN:   if (sig_hit || halt || timeout_hit) state_nxt = ST_DONE;
      ST_DONE:  if (start) state_nxt = ST_RESET;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge mips_cpu_clk) begin
    if (mips_cpu_reset) begin
      rst_cnt     <= '0;
      cycle_count <= '0;
      result      <= RES_HALT;
      halt_pc     <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            rst_cnt     <= '0;
            cycle_count <= '0;
            result      <= RES_HALT;
            halt_pc     <= '0;
          end
        end
        ST_RESET: rst_cnt <= rst_cnt + RST_ONE;
        ST_RUN: begin
          cycle_count <= cycle_count + CNT_ONE;
          if (state_nxt == ST_DONE) begin
            result  <= res_nxt;
            halt_pc <= pc;
          end
        end
        default: rst_cnt <= '0;
      endcase
    end
  end

  assign busy       = (state == ST_RESET) || (state == ST_RUN);
  assign done       = (state == ST_DONE);
  assign core_reset = (state != ST_RUN);

endmodule

// File: tb/tb_mips_cpu_run_ctrl.sv
// Directed bench for mips_cpu_run_ctrl: reset, start timing, pass/fail signature, halt,
// timeout, priority, mid-run reset and rerun from DONE.
module tb_mips_cpu_run_ctrl;

  localparam logic [31:0] SIG     = 32'h0000_0FFC;
  localparam logic [31:0] PC_BASE = 32'h0040_0000;
  localparam logic [31:0] PC_HOLD = 32'h0040_0020;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        core_reset;
  logic [31:0] pc;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic [1:0]  result;
  logic [31:0] cycle_count;
  logic [31:0] halt_pc;

  int errors = 0;
  int checks = 0;

  mips_cpu_run_ctrl #(
    .PC_WIDTH(32), .CNT_WIDTH(32), .RESET_CYCLES(2), .TIMEOUT_CYCLES(250),
    .HALT_REPEAT(4), .SIG_ADDR(32'h0000_0FFC), .PASS_VALUE(32'h0000_0001)
  ) dut (
    .mips_cpu_clk(clk), .mips_cpu_reset(rst), .start(start), .core_reset(core_reset),
    .pc(pc), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .result(result), .cycle_count(cycle_count), .halt_pc(halt_pc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives RUN cycles 1..n; pc advances by 4 each cycle unless held from hold_from.
  task automatic run_cycles(input int n, input int hold_from, input int sig_at,
                            input logic [31:0] sig_data, input int start_at);
    for (int k = 1; k <= n; k++) begin
      pc        = (hold_from != 0 && k >= hold_from) ? PC_HOLD : PC_BASE + 32'(4 * k);
      mem_wen   = (k == sig_at);
      mem_addr  = SIG;
      mem_wdata = sig_data;
      start     = (k == start_at);
      tick();
    end
    mem_wen = 1'b0;
    start   = 1'b0;
  endtask

  // Pulses start and walks through the RESET cycles; returns at RUN cycle 1.
  task automatic run_to_run(input bit noise);
    start = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      start     = noise;
      mem_wen   = noise;
      mem_addr  = SIG;
      mem_wdata = 32'd5;
      tick();
    end
    start   = 1'b0;
    mem_wen = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1;
    tick(); tick();
    checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL reset_core_reset got=%b exp=1", core_reset); end
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_busy_done got=%b exp=00", {busy, done}); end
    checks++; if (result !== 2'd0 || cycle_count !== 32'd0 || halt_pc !== 32'd0) begin errors++;
      $display("FAIL reset_regs got=%0d/%0d/%h exp=0/0/0", result, cycle_count, halt_pc); end
    rst = 1'b0; start = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_stays got busy=%b exp=0", busy); end
  endtask

  task automatic test_startup();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if ({busy, core_reset} !== 2'b11) begin errors++; $display("FAIL start_c6 got busy,core_reset=%b exp=11", {busy, core_reset}); end
    tick();
    checks++; if ({busy, core_reset} !== 2'b11) begin errors++; $display("FAIL start_c7 got busy,core_reset=%b exp=11", {busy, core_reset}); end
    tick();
    checks++; if ({busy, core_reset} !== 2'b10) begin errors++; $display("FAIL start_c8 got busy,core_reset=%b exp=10", {busy, core_reset}); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_pass();
    run_to_run(1'b1);
    checks++; if (core_reset !== 1'b0) begin errors++; $display("FAIL pass_in_run got core_reset=%b exp=0", core_reset); end
    run_cycles(10, 0, 10, 32'd1, 2);
    checks++; if (done !== 1'b1 || busy !== 1'b0 || core_reset !== 1'b1) begin errors++;
      $display("FAIL pass_done got done,busy,core_reset=%b%b%b exp=101", done, busy, core_reset); end
    checks++; if (result !== 2'd1) begin errors++; $display("FAIL pass_result got=%0d exp=1", result); end
    checks++; if (cycle_count !== 32'd10) begin errors++; $display("FAIL pass_count got=%0d exp=10", cycle_count); end
    checks++; if (halt_pc !== 32'h0040_0028) begin errors++; $display("FAIL pass_halt_pc got=%h exp=00400028", halt_pc); end
    run_cycles(3, 0, 2, 32'd5, 0);
    checks++; if (done !== 1'b1 || result !== 2'd1 || cycle_count !== 32'd10) begin errors++;
      $display("FAIL done_hold got done=%b result=%0d count=%0d exp 1/1/10", done, result, cycle_count); end
  endtask

  task automatic test_fail_rerun();
    run_to_run(1'b0);
    checks++; if (cycle_count !== 32'd0 || busy !== 1'b1 || done !== 1'b0) begin errors++;
      $display("FAIL rerun_clear got count=%0d busy=%b done=%b exp 0/1/0", cycle_count, busy, done); end
    run_cycles(10, 0, 10, 32'd5, 0);
    checks++; if (result !== 2'd2) begin errors++; $display("FAIL fail_result got=%0d exp=2", result); end
    checks++; if (cycle_count !== 32'd10) begin errors++; $display("FAIL fail_count got=%0d exp=10", cycle_count); end
  endtask

  task automatic test_halt();
    run_to_run(1'b0);
    run_cycles(9, 6, 0, 32'd0, 0);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL halt_early got done=%b exp=0", done); end
    run_cycles(1, 1, 0, 32'd0, 0);
    checks++; if (done !== 1'b1 || result !== 2'd0) begin errors++; $display("FAIL halt_result got done=%b result=%0d exp 1/0", done, result); end
    checks++; if (halt_pc !== PC_HOLD) begin errors++; $display("FAIL halt_pc got=%h exp=%h", halt_pc, PC_HOLD); end
    checks++; if (cycle_count !== 32'd10) begin errors++; $display("FAIL halt_count got=%0d exp=10", cycle_count); end
  endtask

  task automatic test_timeout();
    run_to_run(1'b0);
    run_cycles(249, 0, 0, 32'd0, 0);
    checks++; if (done !== 1'b0 || cycle_count !== 32'd249) begin errors++;
      $display("FAIL timeout_early got done=%b count=%0d exp 0/249", done, cycle_count); end
    run_cycles(1, 0, 0, 32'd0, 0);
    checks++; if (done !== 1'b1 || result !== 2'd3) begin errors++; $display("FAIL timeout_result got done=%b result=%0d exp 1/3", done, result); end
    checks++; if (cycle_count !== 32'd250) begin errors++; $display("FAIL timeout_count got=%0d exp=250", cycle_count); end
  endtask

  task automatic test_priority();
    run_to_run(1'b0);
    run_cycles(10, 6, 10, 32'd1, 0);
    checks++; if (done !== 1'b1 || result !== 2'd1) begin errors++; $display("FAIL prio_result got done=%b result=%0d exp 1/1", done, result); end
    checks++; if (halt_pc !== PC_HOLD || cycle_count !== 32'd10) begin errors++;
      $display("FAIL prio_regs got pc=%h count=%0d exp %h/10", halt_pc, cycle_count, PC_HOLD); end
  endtask

  task automatic test_mid_run_reset();
    run_to_run(1'b0);
    run_cycles(2, 0, 0, 32'd0, 0);
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    checks++; if ({busy, done, core_reset} !== 3'b001) begin errors++;
      $display("FAIL midrst_state got busy,done,core_reset=%b exp=001", {busy, done, core_reset}); end
    checks++; if (result !== 2'd0 || cycle_count !== 32'd0 || halt_pc !== 32'd0) begin errors++;
      $display("FAIL midrst_regs got=%0d/%0d/%h exp=0/0/0", result, cycle_count, halt_pc); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_idle got busy=%b exp=0", busy); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pc = PC_BASE;
    mem_wen = 1'b0; mem_addr = 32'd0; mem_wdata = 32'd0;
    test_reset();
    test_startup();
    test_pass();
    test_fail_rerun();
    test_halt();
    test_timeout();
    test_priority();
    test_mid_run_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
